// File: rtl/wave_fetch_ctrl_pkg.sv
// Shared constants and types for the wavefront fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wave_fetch_ctrl_pkg;

    localparam int NUM_WF  = 40;
    localparam int WFID_W  = 6;
    localparam int EPOCH_W = 2;

    localparam logic [31:0] PC_INCR = 32'd4;

    // instr_pc_in layout: {pc[31:0], instr[31:0]}
    localparam int IPC_W         = 64;
    localparam int IPC_INSTR_LSB = 0;
    localparam int IPC_PC_LSB    = 32;

    typedef struct packed {
        logic [WFID_W-1:0]  wfid;
        logic [31:0]        pc;
        logic [EPOCH_W-1:0] epoch;
    } fetch_req_t;

endpackage

// File: rtl/wf_rr_arbiter.sv
// Round-robin arbiter over N requesters; search starts at the pointer, pointer moves to winner+1.
// Latency: grant is combinational from req; pointer updates on the clock edge when advance is set.
// Backpressure: pointer holds while advance is low, so a stalled consumer does not rotate priority.
// Ports: req (request vector), advance (consume grant), grant (one-hot), grant_idx (winner index).
module wf_rr_arbiter
    import wave_fetch_ctrl_pkg::*;
#(
    parameter int N     = NUM_WF,
    parameter int IDX_W = WFID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;
    logic             found;

    // Walk ptr, ptr+1, ... with wrap at N (N need not be a power of two).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wave_fetch_ctrl.sv
// Wavefront fetch controller: picks an eligible wavefront, issues fetches, advances PCs, writes responses to queues.
// Latency: eligible -> fetch_req_valid 1 cycle; q_vtail_incr with handshake; q_wr/q_reset/instr_pc_in 1 cycle after cause.
// Backpressure: request held stable while fetch_req_ready is low, unless its wavefront is redirected or halted.
// Ports: wf_start/wf_halt/redirect control, stop_fetch per-wf full, fetch_req_* out (valid/ready),
//        fetch_rsp_* in (always accepted), q_vtail_incr/q_wr/q_reset per-wf pulses, instr_pc_in shared write data.
module wave_fetch_ctrl
    import wave_fetch_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wf_start_valid,
    input  logic [WFID_W-1:0]   wf_start_wfid,
    input  logic [31:0]         wf_start_pc,
    input  logic                wf_halt_valid,
    input  logic [WFID_W-1:0]   wf_halt_wfid,
    input  logic                redirect_valid,
    input  logic [WFID_W-1:0]   redirect_wfid,
    input  logic [31:0]         redirect_pc,
    input  logic [NUM_WF-1:0]   stop_fetch,
    output logic                fetch_req_valid,
    input  logic                fetch_req_ready,
    output logic [WFID_W-1:0]   fetch_req_wfid,
    output logic [31:0]         fetch_req_pc,
    output logic [EPOCH_W-1:0]  fetch_req_epoch,
    input  logic                fetch_rsp_valid,
    input  logic [WFID_W-1:0]   fetch_rsp_wfid,
    input  logic [EPOCH_W-1:0]  fetch_rsp_epoch,
    input  logic [31:0]         fetch_rsp_pc,
    input  logic [31:0]         fetch_rsp_instr,
    output logic [NUM_WF-1:0]   q_vtail_incr,
    output logic [NUM_WF-1:0]   q_wr,
    output logic [NUM_WF-1:0]   q_reset,
    output logic [IPC_W-1:0]    instr_pc_in
);

    logic [NUM_WF-1:0]  active;
    logic [31:0]        pc    [NUM_WF];
    logic [EPOCH_W-1:0] epoch [NUM_WF];

    logic       req_valid;
    fetch_req_t req;

    logic [NUM_WF-1:0] halt_hit, start_hit, redir_hit, kill, touch, elig;
    logic [NUM_WF-1:0] grant;
    logic [WFID_W-1:0] grant_idx;
    logic              hs, req_current, load, rsp_ok;
    logic [31:0]       load_pc;

    always_comb begin
        halt_hit  = '0;
        start_hit = '0;
        redir_hit = '0;
        for (int w = 0; w < NUM_WF; w++) begin
            halt_hit[w]  = wf_halt_valid  && (wf_halt_wfid  == WFID_W'(w));
            start_hit[w] = wf_start_valid && (wf_start_wfid == WFID_W'(w));
            redir_hit[w] = redirect_valid && (redirect_wfid == WFID_W'(w));
        end
    end

    // kill: the wavefront's PC stream is being cut this cycle (no new or held request).
    // touch: the epoch moves this cycle, so responses for it are stale.
    assign kill  = halt_hit | redir_hit;
    assign touch = kill | start_hit;
    assign elig  = active & ~stop_fetch & ~kill;

    assign hs = req_valid && fetch_req_ready;
    // A request whose epoch has moved on must not bump the PC that start/redirect installed.
    assign req_current = (req.epoch == epoch[req.wfid]);
    assign load = !req_valid || fetch_req_ready || kill[req.wfid];

    // Same wavefront re-selected during its own handshake sees the post-increment PC.
    assign load_pc = (hs && req_current && (grant_idx == req.wfid)) ? req.pc + PC_INCR
                                                                    : pc[grant_idx];

    assign rsp_ok = fetch_rsp_valid && (fetch_rsp_wfid < WFID_W'(NUM_WF)) &&
                    (fetch_rsp_epoch == epoch[fetch_rsp_wfid]) && !touch[fetch_rsp_wfid];

    wf_rr_arbiter #(.N(NUM_WF), .IDX_W(WFID_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (elig),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        q_vtail_incr = '0;
        if (hs) begin
            q_vtail_incr[req.wfid] = 1'b1;
        end
    end

    assign fetch_req_valid = req_valid;
    assign fetch_req_wfid  = req.wfid;
    assign fetch_req_pc    = req.pc;
    assign fetch_req_epoch = req.epoch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active      <= '0;
            req_valid   <= 1'b0;
            req         <= '0;
            q_wr        <= '0;
            q_reset     <= '0;
            instr_pc_in <= '0;
            for (int w = 0; w < NUM_WF; w++) begin
                pc[w]    <= '0;
                epoch[w] <= '0;
            end
        end else begin
            if (load) begin
                req_valid <= |grant;
                if (|grant) begin
                    req.wfid  <= grant_idx;
                    req.pc    <= load_pc;
                    req.epoch <= epoch[grant_idx];
                end
            end

            if (hs && req_current) begin
                pc[req.wfid] <= req.pc + PC_INCR;
            end

            // Control events override the issue increment; halt > start > redirect.
            for (int w = 0; w < NUM_WF; w++) begin
                if (halt_hit[w]) begin
                    active[w] <= 1'b0;
                    epoch[w]  <= epoch[w] + EPOCH_W'(1);
                end else if (start_hit[w]) begin
                    active[w] <= 1'b1;
                    pc[w]     <= wf_start_pc;
                    epoch[w]  <= epoch[w] + EPOCH_W'(1);
                end else if (redir_hit[w]) begin
                    pc[w]     <= redirect_pc;
                    epoch[w]  <= epoch[w] + EPOCH_W'(1);
                end
            end

            q_reset <= touch;
            q_wr    <= '0;
            if (rsp_ok) begin
                q_wr[fetch_rsp_wfid]                <= 1'b1;
                instr_pc_in[IPC_PC_LSB +: 32]    <= fetch_rsp_pc;
                instr_pc_in[IPC_INSTR_LSB +: 32] <= fetch_rsp_instr;
            end
        end
    end

endmodule

// File: tb/tb_wave_fetch_ctrl.sv
// Bench for wave_fetch_ctrl: directed vector table, then randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: fetch_req_ready is driven directly (held or randomized).
module tb_wave_fetch_ctrl;
    import wave_fetch_ctrl_pkg::*;

    localparam int OP_NONE = 0, OP_START = 1, OP_HALT = 2, OP_REDIR = 3, OP_HALT_START = 4;
    localparam int X = -1;

    typedef struct {
        int op; int wf; logic [31:0] opc;
        int stop_wf; bit rdy;
        bit rv; int rw; int re; logic [31:0] rpc; logic [31:0] rin;
        bit ev; int ew; logic [31:0] epc; int eep;
        int evt; int eqw; int eqr; logic [63:0] eipc;
    } vec_t;

    typedef struct {
        int wf; logic [EPOCH_W-1:0] ep; logic [31:0] pc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic wf_start_valid, wf_halt_valid, redirect_valid, fetch_req_ready, fetch_rsp_valid;
    logic [WFID_W-1:0] wf_start_wfid, wf_halt_wfid, redirect_wfid, fetch_req_wfid, fetch_rsp_wfid;
    logic [31:0] wf_start_pc, redirect_pc, fetch_req_pc, fetch_rsp_pc, fetch_rsp_instr;
    logic [NUM_WF-1:0] stop_fetch, q_vtail_incr, q_wr, q_reset;
    logic fetch_req_valid;
    logic [EPOCH_W-1:0] fetch_req_epoch, fetch_rsp_epoch;
    logic [IPC_W-1:0] instr_pc_in;

    int checks, errors;
    vec_t vecs[$];
    rsp_t rspq[$];

    // Reference model state
    bit                 m_act [NUM_WF];
    logic [31:0]        m_pc  [NUM_WF];
    logic [EPOCH_W-1:0] m_ep  [NUM_WF];
    bit                 m_rv;
    int                 m_rw, m_ptr;
    logic [31:0]        m_rpc;
    logic [EPOCH_W-1:0] m_rep;
    logic [NUM_WF-1:0]  m_qwr, m_qrst;
    logic [63:0]        m_ipc;

    always #5 clk = ~clk;

    wave_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .wf_start_valid(wf_start_valid), .wf_start_wfid(wf_start_wfid), .wf_start_pc(wf_start_pc),
        .wf_halt_valid(wf_halt_valid), .wf_halt_wfid(wf_halt_wfid),
        .redirect_valid(redirect_valid), .redirect_wfid(redirect_wfid), .redirect_pc(redirect_pc),
        .stop_fetch(stop_fetch),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_req_wfid(fetch_req_wfid), .fetch_req_pc(fetch_req_pc), .fetch_req_epoch(fetch_req_epoch),
        .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_wfid(fetch_rsp_wfid), .fetch_rsp_epoch(fetch_rsp_epoch),
        .fetch_rsp_pc(fetch_rsp_pc), .fetch_rsp_instr(fetch_rsp_instr),
        .q_vtail_incr(q_vtail_incr), .q_wr(q_wr), .q_reset(q_reset), .instr_pc_in(instr_pc_in)
    );

    function automatic logic [NUM_WF-1:0] oh(input int w);
        logic [NUM_WF-1:0] r;
        r = '0;
        if (w >= 0 && w < NUM_WF) r[w] = 1'b1;
        return r;
    endfunction

    function automatic int pick_wf();
        int r;
        r = int'($urandom_range(0, 7));
        return (r < 6) ? r : r + 32;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d actual=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        wf_start_valid = 0; wf_start_wfid = '0; wf_start_pc = '0;
        wf_halt_valid = 0; wf_halt_wfid = '0;
        redirect_valid = 0; redirect_wfid = '0; redirect_pc = '0;
        stop_fetch = '0; fetch_req_ready = 0;
        fetch_rsp_valid = 0; fetch_rsp_wfid = '0; fetch_rsp_epoch = '0;
        fetch_rsp_pc = '0; fetch_rsp_instr = '0;
    endtask

    task automatic add(input int op, input int wf, input logic [31:0] opc, input int stop_wf, input bit rdy,
                       input bit rv, input int rw, input int re, input logic [31:0] rpc, input logic [31:0] rin,
                       input bit ev, input int ew, input logic [31:0] epc, input int eep,
                       input int evt, input int eqw, input int eqr, input logic [63:0] eipc);
        vec_t v;
        v.op = op; v.wf = wf; v.opc = opc; v.stop_wf = stop_wf; v.rdy = rdy;
        v.rv = rv; v.rw = rw; v.re = re; v.rpc = rpc; v.rin = rin;
        v.ev = ev; v.ew = ew; v.epc = epc; v.eep = eep;
        v.evt = evt; v.eqw = eqw; v.eqr = eqr; v.eipc = eipc;
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input vec_t v);
        wf_start_valid  = (v.op == OP_START) || (v.op == OP_HALT_START);
        wf_halt_valid   = (v.op == OP_HALT)  || (v.op == OP_HALT_START);
        redirect_valid  = (v.op == OP_REDIR);
        wf_start_wfid   = WFID_W'(v.wf);
        wf_halt_wfid    = WFID_W'(v.wf);
        redirect_wfid   = WFID_W'(v.wf);
        wf_start_pc     = v.opc;
        redirect_pc     = v.opc;
        stop_fetch      = oh(v.stop_wf);
        fetch_req_ready = v.rdy;
        fetch_rsp_valid = v.rv;
        fetch_rsp_wfid  = WFID_W'(v.rw);
        fetch_rsp_epoch = EPOCH_W'(v.re);
        fetch_rsp_pc    = v.rpc;
        fetch_rsp_instr = v.rin;
    endtask

    task automatic model_reset();
        for (int w = 0; w < NUM_WF; w++) begin
            m_act[w] = 0; m_pc[w] = '0; m_ep[w] = '0;
        end
        m_rv = 0; m_rw = 0; m_ptr = 0; m_rpc = '0; m_rep = '0;
        m_qwr = '0; m_qrst = '0; m_ipc = '0;
        rspq.delete();
    endtask

    // One clock edge of the architectural behaviour, using the inputs currently driven.
    task automatic model_step();
        bit kill [NUM_WF];
        bit touch [NUM_WF];
        logic [31:0] pc_now [NUM_WF];
        logic [NUM_WF-1:0] nqwr;
        bit hs, found;
        int w;
        nqwr = '0;
        hs = m_rv && fetch_req_ready;
        for (int i = 0; i < NUM_WF; i++) begin
            kill[i]  = (wf_halt_valid && int'(wf_halt_wfid) == i) || (redirect_valid && int'(redirect_wfid) == i);
            touch[i] = kill[i] || (wf_start_valid && int'(wf_start_wfid) == i);
            pc_now[i] = m_pc[i];
        end
        if (hs) begin
            rspq.push_back('{m_rw, m_rep, m_rpc});
            if (m_rep == m_ep[m_rw]) pc_now[m_rw] = m_rpc + 32'd4;
        end
        if (fetch_rsp_valid && int'(fetch_rsp_wfid) < NUM_WF) begin
            if (fetch_rsp_epoch == m_ep[fetch_rsp_wfid] && !touch[fetch_rsp_wfid]) begin
                nqwr[fetch_rsp_wfid] = 1'b1;
                m_ipc = {fetch_rsp_pc, fetch_rsp_instr};
            end
        end
        if (!m_rv || fetch_req_ready || kill[m_rw]) begin
            found = 0;
            for (int k = 0; k < NUM_WF; k++) begin
                w = (m_ptr + k) % NUM_WF;
                if (!found && m_act[w] && !stop_fetch[w] && !kill[w]) begin
                    found = 1; m_rw = w; m_rpc = pc_now[w]; m_rep = m_ep[w];
                    m_ptr = (w + 1) % NUM_WF;
                end
            end
            m_rv = found;
        end
        for (int i = 0; i < NUM_WF; i++) begin
            if (wf_halt_valid && int'(wf_halt_wfid) == i) begin
                m_act[i] = 0; m_ep[i] = m_ep[i] + 1'b1;
            end else if (wf_start_valid && int'(wf_start_wfid) == i) begin
                m_act[i] = 1; pc_now[i] = wf_start_pc; m_ep[i] = m_ep[i] + 1'b1;
            end else if (redirect_valid && int'(redirect_wfid) == i) begin
                pc_now[i] = redirect_pc; m_ep[i] = m_ep[i] + 1'b1;
            end
            m_pc[i] = pc_now[i];
            m_qrst[i] = touch[i];
        end
        m_qwr = nqwr;
    endtask

    task automatic rand_drive();
        rsp_t r;
        drive_idle();
        wf_start_valid = ($urandom_range(0, 99) < 8);
        wf_start_wfid  = WFID_W'(pick_wf());
        wf_start_pc    = $urandom & 32'hFFFF_FFFC;
        wf_halt_valid  = ($urandom_range(0, 99) < 4);
        wf_halt_wfid   = WFID_W'(pick_wf());
        redirect_valid = ($urandom_range(0, 99) < 6);
        redirect_wfid  = WFID_W'(pick_wf());
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 99) < 25) stop_fetch = oh(pick_wf()) | oh(pick_wf());
        fetch_req_ready = ($urandom_range(0, 99) < 75);
        if (rspq.size() > 0 && $urandom_range(0, 99) < 50) begin
            r = rspq.pop_front();
            fetch_rsp_valid = 1;
            fetch_rsp_wfid  = WFID_W'(r.wf);
            fetch_rsp_epoch = ($urandom_range(0, 9) == 0) ? EPOCH_W'($urandom_range(0, 3)) : r.ep;
            fetch_rsp_pc    = r.pc;
            fetch_rsp_instr = $urandom;
        end else if ($urandom_range(0, 99) < 3) begin
            fetch_rsp_valid = 1;
            fetch_rsp_wfid  = WFID_W'(50);
            fetch_rsp_pc    = $urandom;
            fetch_rsp_instr = $urandom;
        end
    endtask

    task automatic chk_model(input int cyc);
        chk("rnd_valid", cyc, 64'(fetch_req_valid), 64'(m_rv));
        if (m_rv) begin
            chk("rnd_wfid", cyc, 64'(fetch_req_wfid), 64'(m_rw));
            chk("rnd_pc", cyc, 64'(fetch_req_pc), 64'(m_rpc));
            chk("rnd_epoch", cyc, 64'(fetch_req_epoch), 64'(m_rep));
        end
        chk("rnd_vtail", cyc, 64'(q_vtail_incr), 64'((m_rv && fetch_req_ready) ? oh(m_rw) : '0));
        chk("rnd_q_wr", cyc, 64'(q_wr), 64'(m_qwr));
        chk("rnd_q_reset", cyc, 64'(q_reset), 64'(m_qrst));
        if (m_qwr != '0) chk("rnd_ipc", cyc, instr_pc_in, m_ipc);
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_valid"}, 0, 64'(fetch_req_valid), 64'(0));
        chk({nm, "_vtail"}, 0, 64'(q_vtail_incr), 64'(0));
        chk({nm, "_q_wr"}, 0, 64'(q_wr), 64'(0));
        chk({nm, "_q_reset"}, 0, 64'(q_reset), 64'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        chk("reset_wfid", 0, 64'(fetch_req_wfid), 64'(0));
        chk("reset_pc", 0, 64'(fetch_req_pc), 64'(0));
        chk("reset_epoch", 0, 64'(fetch_req_epoch), 64'(0));
        chk("reset_ipc", 0, instr_pc_in, 64'(0));
        rst = 1'b0;

        //   op            wf pc            stop rdy  rsp: v  wf ep pc        instr          exp: v wf pc        ep  vtail qwr qrst ipc
        add(OP_START,      3, 32'h100,      X, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, 3, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 3, 32'h100,   1,  3, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 3, 32'h104,   1,  3, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 3, 32'h108,   1,  3, X, X, 0);
        add(OP_NONE,       0, 0,            3, 0,     0, 0, 0, 0,         0,             1, 3, 32'h10C,   1,  X, X, X, 0);
        add(OP_NONE,       0, 0,            3, 0,     0, 0, 0, 0,         0,             1, 3, 32'h10C,   1,  X, X, X, 0);
        add(OP_NONE,       0, 0,            3, 1,     0, 0, 0, 0,         0,             1, 3, 32'h10C,   1,  3, X, X, 0);
        add(OP_NONE,       0, 0,            3, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, X, 0);
        add(OP_NONE,       0, 0,            3, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 3, 32'h110,   1,  3, X, X, 0);
        add(OP_REDIR,      3, 32'h200,      X, 1,     0, 0, 0, 0,         0,             1, 3, 32'h114,   1,  3, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     1, 3, 1, 32'h114,   32'h12345678,  0, 0, 0,         0,  X, X, 3, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 3, 32'h200,   2,  3, X, X, 0);
        add(OP_NONE,       0, 0,            X, 0,     1, 3, 2, 32'h200,   32'hDEADBEEF,  1, 3, 32'h204,   2,  X, X, X, 0);
        add(OP_HALT,       3, 0,            X, 0,     0, 0, 0, 0,         0,             1, 3, 32'h204,   2,  X, 3, X, 64'h00000200_DEADBEEF);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, 3, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, X, 0);
        add(OP_START,      0, 32'h1000,     X, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, X, 0);
        add(OP_START,      5, 32'h40,       X, 1,     0, 0, 0, 0,         0,             0, 0, 0,         0,  X, X, 0, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 0, 32'h1000,  1,  0, X, 5, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 5, 32'h40,    1,  5, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 0, 32'h1004,  1,  0, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     1, 5, 1, 32'h40,    32'hDEADBEEF,  1, 5, 32'h44,    1,  5, X, X, 0);
        add(OP_NONE,       0, 0,            X, 0,     0, 0, 0, 0,         0,             1, 0, 32'h1008,  1,  X, 5, X, 64'h00000040_DEADBEEF);
        add(OP_START,      7, 32'h700,      X, 0,     0, 0, 0, 0,         0,             1, 0, 32'h1008,  1,  X, X, X, 0);
        add(OP_HALT_START, 7, 32'h900,      X, 0,     0, 0, 0, 0,         0,             1, 0, 32'h1008,  1,  X, X, 7, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 0, 32'h1008,  1,  0, X, 7, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 5, 32'h48,    1,  5, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 0, 32'h100C,  1,  0, X, X, 0);
        add(OP_NONE,       0, 0,            X, 1,     0, 0, 0, 0,         0,             1, 5, 32'h4C,    1,  5, X, X, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            apply_vec(vecs[i]);
            #2;
            chk("vec_valid", i, 64'(fetch_req_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk("vec_wfid", i, 64'(fetch_req_wfid), 64'(vecs[i].ew));
                chk("vec_pc", i, 64'(fetch_req_pc), 64'(vecs[i].epc));
                chk("vec_epoch", i, 64'(fetch_req_epoch), 64'(vecs[i].eep));
            end
            chk("vec_vtail", i, 64'(q_vtail_incr), 64'(oh(vecs[i].evt)));
            chk("vec_q_wr", i, 64'(q_wr), 64'(oh(vecs[i].eqw)));
            chk("vec_q_reset", i, 64'(q_reset), 64'(oh(vecs[i].eqr)));
            if (vecs[i].eqw >= 0) chk("vec_ipc", i, instr_pc_in, vecs[i].eipc);
        end

        // Randomized phase against the reference model, with one reset mid-run.
        #1;
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 1000) begin
                #1;
                rst = 1'b1;
                #1;
                check_zero_outputs("midreset");
                drive_idle();
                model_reset();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            rand_drive();
            #2;
            chk_model(cyc);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_fetch_ctrl.md
# wave_fetch_ctrl

Write-side controller for the per-wavefront instruction queues. Arbitrates among active wavefronts, issues instruction fetch requests, and advances each wavefront's PC. It reserves a queue slot per request through `q_vtail_incr` and writes returned instruction/PC words through `q_wr`/`instr_pc_in`. On redirect or halt it flushes a wavefront's queue through `q_reset` and discards stale in-flight responses using per-wavefront epoch tags.

## Interface
- NUM_WF, 40, wavefront count
- WFID_W, 6, wavefront id width
- EPOCH_W, 2, epoch tag width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wf_start_valid / wf_start_wfid / wf_start_pc  in  1 / WFID_W / 32  activate wavefront at PC
- wf_halt_valid / wf_halt_wfid  in  1 / WFID_W  deactivate wavefront
- redirect_valid / redirect_wfid / redirect_pc  in  1 / WFID_W / 32  branch redirect
- stop_fetch  in  NUM_WF  per-wavefront virtual-full from queues
- fetch_req_valid  out  1  request valid
- fetch_req_ready  in  1  fetch unit accepts
- fetch_req_wfid / fetch_req_pc / fetch_req_epoch  out  WFID_W / 32 / EPOCH_W
- fetch_rsp_valid  in  1  response valid; always accepted
- fetch_rsp_wfid / fetch_rsp_epoch / fetch_rsp_pc / fetch_rsp_instr  in  WFID_W / EPOCH_W / 32 / 32
- q_vtail_incr  out  NUM_WF  slot reservation pulse
- q_wr  out  NUM_WF  queue write pulse
- q_reset  out  NUM_WF  queue flush pulse
- instr_pc_in  out  64  {pc[31:0], instr[31:0]}, shared by all queues

## Operation
- Per-wavefront state: active, pc[31:0], epoch[EPOCH_W-1:0].
- Eligibility: active & ~stop_fetch & not targeted by a redirect/halt this cycle.
- Request register: loaded when empty (or handshaking this cycle) from the round-robin winner. The round-robin pointer moves to the winner+1.
- Handshake (valid & ready): `q_vtail_incr[wfid]`=1 that cycle (combinational). The issued wavefront's pc += 4, mod 2^32.
- While valid & ~ready: wfid/pc/epoch are held stable. The sole exception is a redirect or halt of the same wfid, which retracts the request next cycle.
- Response: if `fetch_rsp_epoch == epoch[wfid]` and the wfid is not targeted by a redirect/halt this cycle, then next cycle `q_wr[wfid]`=1 and `instr_pc_in`={rsp_pc, rsp_instr}. Otherwise the response is dropped silently.
- Redirect: pc←redirect_pc, epoch+=1 (wraps), `q_reset[wfid]`=1 next cycle.
- Halt: active←0, epoch+=1, `q_reset[wfid]`=1 next cycle.
- Start: active←1, pc←start_pc, epoch+=1, `q_reset[wfid]`=1 next cycle.
- Same-wfid conflicts: halt > start > redirect.
- q_reset and q_wr are never both asserted for the same wfid in one cycle.

## Timing
- Reset: all outputs 0; active, pc, epoch and round-robin pointer all 0; request register empty.
- Minimum latency from eligible to fetch_req_valid: 1 cycle.
- Back-to-back requests with ready held high: 1 per cycle (same wavefront allowed if still eligible).
- q_vtail_incr: same cycle as handshake. q_wr, instr_pc_in, q_reset: registered, 1 cycle after the causing event.
- stop_fetch sampled each cycle. A wavefront that reaches virtual-full is not re-selected next cycle, except for a request already held in the register.
- Reset asserted mid-operation: request dropped immediately; in-flight responses after reset carry epoch≠0 only by coincidence. Software must not release reset with fetches outstanding.

## Structure
- Shared package (wavepool pkg): NUM_WF, WFID_W, EPOCH_W, PC_INCR=4, field positions within instr_pc_in.
- Sub-module `wf_rr_arbiter`: NUM_WF-wide round-robin, inputs req vector + advance, outputs grant one-hot + grant index.
- The remainder is flat: state arrays, request register, response register.

## Test plan
- Reset then start wf3 at 0x100, ready=1 → requests pc 0x100, 0x104, 0x108 on consecutive cycles. q_vtail_incr[3] pulses each cycle.
- Start wf0 and wf5, both eligible, ready=1 → grants alternate 0,5,0,5.
- stop_fetch[3]=1 with ready=0 holding a wf3 request → request stays stable until ready. Afterward no new wf3 request until stop_fetch deasserts.
- Redirect wf3 to 0x200 with a response tagged with the old epoch arriving the next cycle → q_reset[3] pulses, no q_wr[3]. The next request pc is 0x200.
- Matching response wf5 pc 0x40 instr 0xDEADBEEF → one cycle later q_wr[5]=1, instr_pc_in=0x00000040_DEADBEEF.
- Halt and start of wf7 in the same cycle → halt wins: q_reset[7]=1, no further wf7 requests.
